// File: rtl/i2s_rx_drain_ctrl_pkg.sv
// Shared definitions for the i2s receive drain sequencer.
//   I2S_FLW / I2S_BLW : default FIFO-level and burst-length field widths
//   WORD_SHIFT        : byte-address shift for 32-bit words
//   state_t, ST_*     : drain FSM state encoding
package i2s_pkg;

  localparam int unsigned I2S_FLW    = 5;
  localparam int unsigned I2S_BLW    = 4;
  localparam int unsigned WORD_SHIFT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_POP   = 2'd1;
  localparam state_t ST_WRITE = 2'd2;

endpackage

// File: rtl/i2s_rx_drain_ctrl.sv
// Drains the i2s receive FIFO in bursts and writes each word into a circular
// memory buffer over a valid/ready master port.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   en, rewind               drain enable, index reset pulse (IDLE only)
//   buf_base, buf_words      circular buffer byte base and length in words
//   burst_len                max words per burst (0 behaves as 1)
//   fifo_level(_above)       FIFO occupancy and threshold flag
//   fifo_rdata, fifo_rd      show-ahead head word and pop strobe
//   m_valid/m_ready/m_addr/m_wdata   write master port
//   busy, irq_half, irq_wrap, idx    status, interrupt pulses, next word index
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for en & FIFO above threshold; rewind honoured here
//   ST_POP   | one cycle: fifo_rd high, head word and address captured
//   ST_WRITE | m_valid held until accepted; index/IRQ update on handshake
module i2s_rx_drain_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned FLW = I2S_FLW,
  parameter int unsigned BLW = I2S_BLW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           rewind,
  input  logic [AW-1:0]  buf_base,
  input  logic [15:0]    buf_words,
  input  logic [BLW-1:0] burst_len,
  input  logic [FLW-1:0] fifo_level,
  input  logic           fifo_level_above,
  input  logic [31:0]    fifo_rdata,
  output logic           fifo_rd,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [AW-1:0]  m_addr,
  output logic [31:0]    m_wdata,
  output logic           busy,
  output logic           irq_half,
  output logic           irq_wrap,
  output logic [15:0]    idx
);

  localparam int unsigned CW = (FLW > BLW) ? FLW : BLW;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     idx_q, idx_d;
  logic            fifo_rd_q, fifo_rd_d;
  logic            m_valid_q, m_valid_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic            busy_q, busy_d;
  logic            irq_half_q, irq_half_d;
  logic            irq_wrap_q, irq_wrap_d;

  logic [CW-1:0]   blen_eff;
  logic [CW-1:0]   lvl;
  logic [CW-1:0]   burst_cnt;
  logic [15:0]     idx_nxt;
  logic            idx_last;

  always_comb begin
    blen_eff  = (burst_len == '0) ? CW'(1) : CW'(burst_len);
    lvl       = CW'(fifo_level);
    burst_cnt = (lvl < blen_eff) ? lvl : blen_eff;
    idx_last  = (idx_q == buf_words - 16'd1);
    idx_nxt   = idx_last ? 16'd0 : idx_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    irq_half_d = 1'b0;
    irq_wrap_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rewind) begin
          idx_d = 16'd0;
        end
        // An empty FIFO with the threshold flag set would give a zero-length
        // burst, so level must also be non-zero before popping.
        if (en && fifo_level_above && (buf_words != 16'd0) && (fifo_level != '0)) begin
          cnt_d   = burst_cnt;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        m_wdata_d = fifo_rdata;
        // idx_d (not idx_q) so a same-cycle rewind would be seen; in POP they match.
        m_addr_d  = buf_base + (AW'(idx_d) << WORD_SHIFT);
        m_valid_d = 1'b1;
        state_d   = ST_WRITE;
      end

      ST_WRITE: begin
        if (m_valid_q && m_ready) begin
          m_valid_d  = 1'b0;
          cnt_d      = cnt_q - CW'(1);
          idx_d      = idx_nxt;
          irq_wrap_d = idx_last;
          irq_half_d = (buf_words >= 16'd2) && (idx_nxt == (buf_words >> 1));
          state_d    = ((cnt_d != '0) && en) ? ST_POP : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered strobes: fifo_rd is high exactly during POP, busy whenever not IDLE.
    fifo_rd_d = (state_d == ST_POP);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 16'd0;
      fifo_rd_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= 32'd0;
      busy_q     <= 1'b0;
      irq_half_q <= 1'b0;
      irq_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      fifo_rd_q  <= fifo_rd_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      busy_q     <= busy_d;
      irq_half_q <= irq_half_d;
      irq_wrap_q <= irq_wrap_d;
    end
  end

  assign fifo_rd  = fifo_rd_q;
  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = busy_q;
  assign irq_half = irq_half_q;
  assign irq_wrap = irq_wrap_q;
  assign idx      = idx_q;

endmodule

// File: tb/tb_i2s_rx_drain_ctrl.sv
// Directed bench for i2s_rx_drain_ctrl with a show-ahead FIFO model.
// FIFO word n (in push order) carries data 0xA000_0000 + n.
module tb_i2s_rx_drain_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rewind;
  logic [31:0] buf_base;
  logic [15:0] buf_words;
  logic [3:0]  burst_len;
  logic [4:0]  fifo_level;
  logic        fifo_level_above;
  logic [31:0] fifo_rdata;
  logic        fifo_rd;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        busy;
  logic        irq_half;
  logic        irq_wrap;
  logic [15:0] idx;

  i2s_rx_drain_ctrl #(.AW(32), .FLW(5), .BLW(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .rewind           (rewind),
    .buf_base         (buf_base),
    .buf_words        (buf_words),
    .burst_len        (burst_len),
    .fifo_level       (fifo_level),
    .fifo_level_above (fifo_level_above),
    .fifo_rdata       (fifo_rdata),
    .fifo_rd          (fifo_rd),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_addr           (m_addr),
    .m_wdata          (m_wdata),
    .busy             (busy),
    .irq_half         (irq_half),
    .irq_wrap         (irq_wrap),
    .idx              (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model
  logic [31:0] fifo_mem [0:63];
  int wr_ptr;
  int rd_ptr;
  int thr;

  initial rd_ptr = 0;
  always @(posedge clk) begin
    if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  assign fifo_level       = 5'(wr_ptr - rd_ptr);
  assign fifo_rdata       = fifo_mem[rd_ptr % 64];
  assign fifo_level_above = ((wr_ptr - rd_ptr) >= thr);

  // Monitor
  logic [31:0] wa [0:255];
  logic [31:0] wd [0:255];
  int nwr, nrd, rd_b2b, nbursts;
  int half_cnt, half_at, wrap_cnt, wrap_at;
  logic rd_prev, busy_prev;

  initial begin
    nwr = 0; nrd = 0; rd_b2b = 0; nbursts = 0;
    half_cnt = 0; half_at = 0; wrap_cnt = 0; wrap_at = 0;
    rd_prev = 1'b0; busy_prev = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (irq_half) begin half_cnt++; half_at = nwr; end
      if (irq_wrap) begin wrap_cnt++; wrap_at = nwr; end
      if (fifo_rd) begin
        nrd++;
        if (rd_prev) rd_b2b++;
      end
      rd_prev = fifo_rd;
      if (busy && !busy_prev) nbursts++;
      busy_prev = busy;
      if (m_valid && m_ready) begin
        wa[nwr] = m_addr;
        wd[nwr] = m_wdata;
        nwr++;
      end
    end
  end

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 64] = 32'hA000_0000 + 32'(wr_ptr);
      wr_ptr++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int run = 0;
    int n = 0;
    while (run < 4 && n < 300) begin
      @(negedge clk);
      n++;
      run = busy ? 0 : run + 1;
    end
    chk(tag, 32'(run >= 4), 32'd1);
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (nwr < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(nwr >= target), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  task automatic do_rewind();
    en = 1'b0;
    rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    tick(1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fifo_rd"},  32'(fifo_rd),  32'd0);
    chk({tag, "_m_valid"},  32'(m_valid),  32'd0);
    chk({tag, "_m_addr"},   m_addr,        32'd0);
    chk({tag, "_m_wdata"},  m_wdata,       32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_irq_half"}, 32'(irq_half), 32'd0);
    chk({tag, "_irq_wrap"}, 32'(irq_wrap), 32'd0);
    chk({tag, "_idx"},      32'(idx),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  int b, r, hc, wc, nb;

  initial begin
    checks = 0; failures = 0;
    wr_ptr = 0; thr = 3;
    rst_n = 1'b0; en = 1'b0; rewind = 1'b0;
    buf_base = 32'h1000; buf_words = 16'd16; burst_len = 4'd4; m_ready = 1'b1;
    tick(3);
    chk_reset("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic burst: 6 in FIFO, burst 4 -> words 0..3 at 0x1000..0x100C
    push(6);
    b = nwr; r = nrd;
    en = 1'b1;
    tick(1);
    wait_idle("basic_idle");
    chk("basic_nwr", 32'(nwr - b), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("basic_addr", wa[b + k], 32'h1000 + 32'(4 * k));
      chk("basic_data", wd[b + k], 32'hA000_0000 + 32'(k));
    end
    chk("basic_nrd", 32'(nrd - r), 32'd4);
    chk("basic_rd_b2b", 32'(rd_b2b), 32'd0);
    chk("basic_idx", 32'(idx), 32'd4);

    // Backpressure on beat 2: words 4..7 to 0x1010..0x101C
    en = 1'b0;
    push(4);
    b = nwr; r = nrd;
    en = 1'b1;
    wait_wr(b + 1, "bp_beat1");
    m_ready = 1'b0;
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_hold_addr", m_addr, 32'h1014);
      chk("bp_hold_data", m_wdata, 32'hA000_0005);
      chk("bp_hold_nrd", 32'(nrd - r), 32'd2);
      tick(1);
    end
    m_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_nwr", 32'(nwr - b), 32'd4);
    chk("bp_last_addr", wa[b + 3], 32'h101C);
    chk("bp_last_data", wd[b + 3], 32'hA000_0007);
    chk("bp_nrd", 32'(nrd - r), 32'd4);
    chk("bp_idx", 32'(idx), 32'd8);

    // Wrap and IRQs: buf_words 8, 10 words (8..17)
    hc = half_cnt; wc = wrap_cnt;
    do_rewind();
    chk("rw8_idx", 32'(idx), 32'd0);
    buf_words = 16'd8; thr = 1;
    push(8);
    b = nwr;
    en = 1'b1;
    tick(1);
    wait_idle("wrap_idle");
    chk("wrap_nwr", 32'(nwr - b), 32'd10);
    chk("wrap_half_cnt", 32'(half_cnt - hc), 32'd1);
    chk("wrap_half_at", 32'(half_at - b), 32'd4);
    chk("wrap_wrap_cnt", 32'(wrap_cnt - wc), 32'd1);
    chk("wrap_wrap_at", 32'(wrap_at - b), 32'd8);
    chk("wrap_9th_addr", wa[b + 8], 32'h1000);
    chk("wrap_9th_data", wd[b + 8], 32'hA000_0010);
    chk("wrap_idx", 32'(idx), 32'd2);

    // Short FIFO: burst 8, level 3 (words 18..20)
    en = 1'b0;
    buf_words = 16'd16; burst_len = 4'd8; thr = 3;
    push(3);
    b = nwr; r = nrd;
    en = 1'b1;
    tick(1);
    wait_idle("short_idle");
    chk("short_nwr", 32'(nwr - b), 32'd3);
    chk("short_nrd", 32'(nrd - r), 32'd3);
    chk("short_last_addr", wa[b + 2], 32'h1010);
    chk("short_idx", 32'(idx), 32'd5);

    // Rewind from idx 5: no IRQ
    hc = half_cnt; wc = wrap_cnt;
    do_rewind();
    tick(1);
    chk("rewind_idx", 32'(idx), 32'd0);
    chk("rewind_no_half", 32'(half_cnt - hc), 32'd0);
    chk("rewind_no_wrap", 32'(wrap_cnt - wc), 32'd0);

    // burst_len 0 -> one word per burst (words 21, 22)
    burst_len = 4'd0; thr = 1;
    b = nwr; nb = nbursts;
    push(2);
    en = 1'b1;
    tick(1);
    wait_idle("bl0_idle");
    chk("bl0_nwr", 32'(nwr - b), 32'd2);
    chk("bl0_bursts", 32'(nbursts - nb), 32'd2);
    chk("bl0_data", wd[b + 1], 32'hA000_0016);
    chk("bl0_idx", 32'(idx), 32'd2);

    // Disable mid-burst (words 23..28)
    do_rewind();
    burst_len = 4'd4; thr = 3;
    push(6);
    b = nwr; r = nrd;
    en = 1'b1;
    wait_wr(b + 1, "dis_beat1");
    m_ready = 1'b0;
    wait_valid("dis_valid");
    en = 1'b0;
    tick(3);
    m_ready = 1'b1;
    wait_idle("dis_idle");
    chk("dis_nwr", 32'(nwr - b), 32'd2);
    chk("dis_nrd", 32'(nrd - r), 32'd2);
    chk("dis_addr2", wa[b + 1], 32'h1004);
    chk("dis_idx", 32'(idx), 32'd2);
    en = 1'b1;
    tick(1);
    wait_idle("reen_idle");
    chk("reen_addr", wa[b + 2], 32'h1008);
    chk("reen_data", wd[b + 2], 32'hA000_0019);
    chk("reen_idx", 32'(idx), 32'd6);

    // Rewind in the same cycle as the IDLE->POP decision (words 29..31)
    en = 1'b0; thr = 3;
    push(3);
    b = nwr;
    en = 1'b1; rewind = 1'b1;
    tick(1);
    rewind = 1'b0;
    wait_idle("rwgo_idle");
    chk("rwgo_addr", wa[b], 32'h1000);
    chk("rwgo_data", wd[b], 32'hA000_001D);
    chk("rwgo_idx", 32'(idx), 32'd3);

    // buf_words 1: every write wraps, no half (words 32..34)
    do_rewind();
    buf_words = 16'd1; thr = 1;
    hc = half_cnt; wc = wrap_cnt;
    push(3);
    b = nwr;
    en = 1'b1;
    tick(1);
    wait_idle("bw1_idle");
    chk("bw1_nwr", 32'(nwr - b), 32'd3);
    chk("bw1_wraps", 32'(wrap_cnt - wc), 32'd3);
    chk("bw1_halfs", 32'(half_cnt - hc), 32'd0);
    chk("bw1_addr", wa[b + 2], 32'h1000);
    chk("bw1_idx", 32'(idx), 32'd0);

    // buf_words 0 holds IDLE
    en = 1'b0;
    buf_words = 16'd0;
    push(1);
    nb = nbursts; r = nrd;
    en = 1'b1;
    tick(10);
    chk("bw0_busy", 32'(busy), 32'd0);
    chk("bw0_bursts", 32'(nbursts - nb), 32'd0);
    chk("bw0_nrd", 32'(nrd - r), 32'd0);

    // Reset during WRITE
    m_ready = 1'b0;
    buf_words = 16'd16;
    wait_valid("rst_valid");
    rst_n = 1'b0;
    tick(1);
    chk_reset("midrst");
    en = 1'b0;
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
